uart_tx_fifo_drain: RTL and testbench

//  UART transmitter stage directly downstream of the TX FIFO. Pops one word whenever the FIFO is non-empty and the line is idle.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_fifo_drain.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling and stop-length constants.
package uart_pkg;

  // Raw 2-bit state encodings, kept visible so other stages can decode them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Oversample ticks per bit period.
  localparam int OVERSAMPLE = 16;

  // Oversample ticks in the stop phase for 1, 1.5 and 2 stop bits.
  localparam int STOP_1   = 16;
  localparam int STOP_1P5 = 24;
  localparam int STOP_2   = 32;

  // Width of the oversample tick counter; covers stop phases up to 32 ticks.
  localparam int TICK_W = 5;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks, restartable via clear.
module uart_baud_gen #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  // Next divider count: restart on clear, wrap at the terminal count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Divider count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign tick = (cnt_r == CNT_MAX);

endmodule : uart_baud_gen

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through TX FIFO, one frame per word.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int BAUD_DIV   = 54,
  parameter int STOP_TICKS = STOP_1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [TICK_W-1:0] TICK_ZERO     = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE      = TICK_W'(1);
  localparam logic [TICK_W-1:0] BIT_LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST     = TICK_W'(STOP_TICKS - 1);
  localparam logic [BW-1:0]     BIT_ZERO      = {BW{1'b0}};
  localparam logic [BW-1:0]     BIT_ONE       = BW'(1);
  localparam logic [BW-1:0]     BIT_LAST      = BW'(DATA_SIZE - 1);

  uart_state_e            state_r,  state_nxt_s;
  logic [DATA_SIZE-1:0]   shift_r,  shift_nxt_s;
  logic [TICK_W-1:0]      tick_r,   tick_nxt_s;
  logic [BW-1:0]          bit_r,    bit_nxt_s;
  logic                   tx_r,     tx_nxt_s;
  logic                   done_s;
  logic                   pop_s;
  logic                   baud_tick_s;

  // Pop only from IDLE; the state leaves IDLE on the same edge, so this is a single-cycle strobe.
  assign pop_s = (state_r == IDLE) & ~fifo_empty & ~reset;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clear (pop_s),
    .tick  (baud_tick_s)
  );

  // Next-state, datapath and Mealy done pulse for the start/data/stop sequence.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    tick_nxt_s  = tick_r;
    bit_nxt_s   = bit_r;
    tx_nxt_s    = tx_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          state_nxt_s = START;
          shift_nxt_s = fifo_data;
          tick_nxt_s  = TICK_ZERO;
          bit_nxt_s   = BIT_ZERO;
          tx_nxt_s    = 1'b0;
        end else begin
          tx_nxt_s    = 1'b1;
        end
      end
      START: begin
        if (baud_tick_s) begin
          if (tick_r == BIT_LAST_TICK) begin
            state_nxt_s = DATA;
            tick_nxt_s  = TICK_ZERO;
            tx_nxt_s    = shift_r[0];
          end else begin
            tick_nxt_s  = tick_r + TICK_ONE;
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          if (tick_r == BIT_LAST_TICK) begin
            tick_nxt_s  = TICK_ZERO;
            shift_nxt_s = {1'b0, shift_r[DATA_SIZE-1:1]};
            if (bit_r == BIT_LAST) begin
              state_nxt_s = STOP;
              tx_nxt_s    = 1'b1;
            end else begin
              bit_nxt_s   = bit_r + BIT_ONE;
              tx_nxt_s    = shift_nxt_s[0];
            end
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      STOP: begin
        if (baud_tick_s) begin
          if (tick_r == STOP_LAST) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
            tick_nxt_s  = TICK_ZERO;
          end else begin
            tick_nxt_s  = tick_r + TICK_ONE;
          end
        end else begin
          tick_nxt_s = tick_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tick_nxt_s  = TICK_ZERO;
        bit_nxt_s   = BIT_ZERO;
        tx_nxt_s    = 1'b1;
      end
    endcase
  end

  // State, shift register, counters and the registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      shift_r <= {DATA_SIZE{1'b0}};
      tick_r  <= TICK_ZERO;
      bit_r   <= BIT_ZERO;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      tick_r  <= tick_nxt_s;
      bit_r   <= bit_nxt_s;
      tx_r    <= tx_nxt_s;
    end
  end

  assign fifo_read    = pop_s;
  assign tx           = tx_r;
  assign tx_busy      = (state_r != IDLE);
  assign tx_done_tick = done_s;

endmodule : uart_tx_fifo_drain

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: frame timing, back-to-back pops, reset, long stop, random words.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // FIFO model for the 1-stop-bit instance
  logic [7:0] mem0 [0:63];
  logic [6:0] wr0 = 7'd0;
  logic [6:0] rd0 = 7'd0;
  logic       fifo_empty0, fifo_read0, tx0, busy0, done0;
  logic [7:0] fifo_data0;

  // FIFO model for the 2-stop-bit instance
  logic [7:0] mem1 [0:63];
  logic [6:0] wr1 = 7'd0;
  logic [6:0] rd1 = 7'd0;
  logic       fifo_empty1, fifo_read1, tx1, busy1, done1;
  logic [7:0] fifo_data1;

  int tests  = 0;
  int failed = 0;

  assign fifo_empty0 = (wr0 == rd0);
  assign fifo_data0  = mem0[rd0[5:0]];
  assign fifo_empty1 = (wr1 == rd1);
  assign fifo_data1  = mem1[rd1[5:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read0) rd0 <= rd0 + 7'd1;
    if (fifo_read1) rd1 <= rd1 + 7'd1;
  end

  uart_tx_fifo_drain #(.DATA_SIZE(8), .BAUD_DIV(4), .STOP_TICKS(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
    .fifo_read(fifo_read0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0));

  uart_tx_fifo_drain #(.DATA_SIZE(8), .BAUD_DIV(4), .STOP_TICKS(32)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_read(fifo_read1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] w);
    mem0[wr0[5:0]] = w;
    wr0 = wr0 + 7'd1;
  endtask

  // Checks cycles T+1..T+576+stop_len after a pop observed in the current cycle T.
  task automatic frame_check(input logic [7:0] word, input int stop_len, input bit sel, input string tag);
    int tx_bad = 0, done_bad = 0, busy_bad = 0, rd_bad = 0;
    int total;
    logic e_tx, o_tx, o_done, o_busy, o_rd;
    total = 576 + stop_len;
    for (int k = 1; k <= total; k++) begin
      step();
      if (k <= 64)       e_tx = 1'b0;
      else if (k <= 576) e_tx = word[(k - 65) / 64];
      else               e_tx = 1'b1;
      o_tx   = sel ? tx1 : tx0;
      o_done = sel ? done1 : done0;
      o_busy = sel ? busy1 : busy0;
      o_rd   = sel ? fifo_read1 : fifo_read0;
      if (o_tx !== e_tx) tx_bad++;
      if (o_done !== (k == total)) done_bad++;
      if (o_busy !== 1'b1) busy_bad++;
      if (o_rd !== 1'b0) rd_bad++;
    end
    chk({tag, "_tx_bad_cycles"}, tx_bad, 0);
    chk({tag, "_done_bad_cycles"}, done_bad, 0);
    chk({tag, "_busy_bad_cycles"}, busy_bad, 0);
    chk({tag, "_read_bad_cycles"}, rd_bad, 0);
  endtask

  initial begin
    logic [6:0] rd_mark;
    int bad_tx, bad_rd, bad_busy, bad_done;
    logic [7:0] exp_q [0:5];
    logic [7:0] got;
    int frame_err;
    bit found;

    // reset state
    step(); step();
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_read", fifo_read0, 0);
    @(negedge clk);
    push0(8'hA5);
    #1;
    chk("rst_read_forced_low", fifo_read0, 0);
    step();
    chk("rst_read_forced_low2", fifo_read0, 0);

    // test 1: 0xA5, pop on reset release
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t1_pop", fifo_read0, 1);
    frame_check(8'hA5, 64, 1'b0, "t1");
    step();
    chk("t1_busy_after", busy0, 0);
    chk("t1_tx_after", tx0, 1);
    chk("t1_read_after", fifo_read0, 0);

    // test 2: back-to-back 0x00, 0xFF
    rd_mark = rd0;
    @(negedge clk);
    push0(8'h00);
    push0(8'hFF);
    #1;
    chk("t2_pop1", fifo_read0, 1);
    frame_check(8'h00, 64, 1'b0, "t2a");
    step();
    chk("t2_pop2_at_641", fifo_read0, 1);
    chk("t2_tx_idle_641", tx0, 1);
    chk("t2_busy_641", busy0, 0);
    frame_check(8'hFF, 64, 1'b0, "t2b");
    step();
    chk("t2_busy_end", busy0, 0);
    step(); step();
    chk("t2_pop_count", 32'(rd0 - rd_mark), 2);

    // test 3: empty FIFO for 1000 cycles
    bad_tx = 0; bad_rd = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx0 !== 1'b1) bad_tx++;
      if (fifo_read0 !== 1'b0) bad_rd++;
      if (busy0 !== 1'b0) bad_busy++;
      if (done0 !== 1'b0) bad_done++;
    end
    chk("t3_tx", bad_tx, 0);
    chk("t3_read", bad_rd, 0);
    chk("t3_busy", bad_busy, 0);
    chk("t3_done", bad_done, 0);

    // test 4: reset mid-DATA
    rd_mark = rd0;
    @(negedge clk);
    push0(8'h5A);
    #1;
    chk("t4_pop", fifo_read0, 1);
    repeat (299) step();
    chk("t4_tx_bit3_before_reset", tx0, 1);
    chk("t4_busy_before_reset", busy0, 1);
    @(negedge clk);
    reset = 1'b1;
    push0(8'hC3);
    #1;
    chk("t4_read_in_reset", fifo_read0, 0);
    step();
    chk("t4_tx_301", tx0, 1);
    chk("t4_busy_301", busy0, 0);
    chk("t4_read_301", fifo_read0, 0);
    bad_rd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fifo_read0 !== 1'b0) bad_rd++;
    end
    chk("t4_read_held_low", bad_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t4_pop_after_release", fifo_read0, 1);
    chk("t4_no_repop", 32'(rd0 - rd_mark), 1);
    frame_check(8'hC3, 64, 1'b0, "t4");
    step();
    chk("t4_busy_end", busy0, 0);

    // test 5: two stop bits on the second instance
    @(negedge clk);
    mem1[wr1[5:0]] = 8'h3C;
    wr1 = wr1 + 7'd1;
    #1;
    chk("t5_pop", fifo_read1, 1);
    frame_check(8'h3C, 128, 1'b1, "t5");
    step();
    chk("t5_busy_end", busy1, 0);
    chk("t5_tx_end", tx1, 1);

    // test 6: random words recovered by a bit-centre monitor
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      exp_q[i] = 8'($urandom_range(0, 255));
      push0(exp_q[i]);
    end
    #1;
    frame_err = 0;
    for (int w = 0; w < 6; w++) begin
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        step();
        if (tx0 === 1'b0) begin
          found = 1'b1;
          break;
        end
      end
      chk("t6_start_found", {31'd0, found}, 1);
      if (!found) break;
      repeat (32) step();
      if (tx0 !== 1'b0) frame_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (64) step();
        got[b] = tx0;
      end
      repeat (64) step();
      if (tx0 !== 1'b1) frame_err++;
      chk($sformatf("t6_word%0d", w), got, exp_q[w]);
    end
    chk("t6_framing_errors", frame_err, 0);
    chk("t6_fifo_drained", {31'd0, fifo_empty0}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_uart_tx_fifo_drain
